branch_checkpoint_manager: RTL and testbench
============================================

Name: branch_checkpoint_manager

Overview:
- Owns the branch checkpoint slots (branch id, color, GHR, free-list head, delay-slot flag) that misprediction recovery restores from.
- Allocates a slot when rename dispatches a branch. Frees the slot on correct resolution.
- On a mispredict, squashes younger slots and sequences a registered, one-cycle recovery pulse that drives the rename, active-list and GHR restore.
- Sits between rename/dispatch and the misprediction recovery logic. Slot index is also used by rename to address its rename-buffer snapshot.

Parameters:
- BRANCH_NUM, 4, number of checkpoint slots
- BRANCH_NUM_INDEX, 2, log2(BRANCH_NUM)
- ACTIVE_LIST_SIZE, 64, active-list entries (power of two)
- ACTIVE_LIST_SIZE_INDEX, 6, log2(ACTIVE_LIST_SIZE)
- PHYS_REG_NUM_INDEX, 6, free-list pointer width
- GHR_LEN, 8, global history width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- alloc_req  in  1  rename requests a checkpoint for a branch
- alloc_branch_id  in  ACTIVE_LIST_SIZE_INDEX  active-list id of branch
- alloc_color  in  1  color bit of branch
- alloc_ghr  in  GHR_LEN  GHR after prediction, LSB = predicted direction
- alloc_free_head  in  PHYS_REG_NUM_INDEX  free-list head snapshot
- alloc_ds  in  1  delay slot dispatched together with branch
- alloc_ready  out  1  slot available and no recovery in progress
- alloc_slot  out  BRANCH_NUM_INDEX  slot granted (valid when alloc_req && alloc_ready)
- resolve_valid  in  1  branch resolved this cycle
- resolve_branch_id  in  ACTIVE_LIST_SIZE_INDEX  resolved branch id
- resolve_color  in  1  resolved branch color
- resolve_miss  in  1  resolution was a mispredict
- valid_mask  out  BRANCH_NUM  live slots
- recover_valid  out  1  one-cycle restore pulse
- recover_slot  out  BRANCH_NUM_INDEX  slot being restored
- recover_ghr  out  GHR_LEN  stored GHR with LSB inverted
- recover_free_head  out  PHYS_REG_NUM_INDEX  stored free-list head
- recover_youngest_ptr  out  ACTIVE_LIST_SIZE_INDEX  new active-list tail
- recover_global_color  out  1  new global color bit

Behaviour:
- Reset (rst_n=0 at posedge):
  - valid_mask=0, state=IDLE.
  - recover_valid=0; all recover_* outputs = 0.
  - alloc_ready=1 on the first cycle after reset.
- Allocation:
  - alloc_ready = !(&valid_mask) && state==IDLE && !(resolve_valid && resolve_miss).
  - alloc_slot = lowest-index free slot (priority encoder, bottom-up), combinational.
  - On alloc_req && alloc_ready: slot fields written and valid set at the posedge. Grant in the same cycle, zero latency.
  - alloc_req when not ready is dropped. Rename must hold the request.
- Match: resolve hits slot i iff valid_mask[i] && id[i]==resolve_branch_id && color[i]==resolve_color. No hit means the resolution is ignored, with no state change.
- Correct resolve (hit, !resolve_miss): clear valid[i] at the posedge.
- Simultaneous alloc and correct resolve:
  - Both take effect.
  - The slot freed this cycle is not reallocated until the next cycle.
- Age rule (entry e is younger than branch B):
  - color[e]==B.color and id[e] > B.id, or
  - color[e]!=B.color and id[e] < B.id.
- Mispredict (hit on slot m):
  - At the posedge, clear valid[m] and every valid slot younger than m. Enter RECOVER.
  - Register: recover_slot=m; recover_ghr={ghr[m][GHR_LEN-1:1], ~ghr[m][0]}; recover_free_head=free_head[m].
  - Let last = id[m] + ds[m]. Carry the color: lastcolor = color[m] ^ (ds[m] && id[m]==ACTIVE_LIST_SIZE-1).
  - recover_youngest_ptr = last+1, mod ACTIVE_LIST_SIZE.
  - recover_global_color = lastcolor ^ (last==ACTIVE_LIST_SIZE-1).
- FSM:
  - IDLE → RECOVER on a mispredict hit.
  - RECOVER: recover_valid=1 for exactly one cycle, alloc_ready=0, and all resolves are ignored (they belong to squashed paths).
  - RECOVER → IDLE unconditionally.
- Mispredict with no hit: ignored, remain IDLE.
- Two resolves cannot arrive in one cycle (single resolve port).
- Reset asserted during RECOVER: reset wins, return to IDLE, no pulse.

Decomposition:
- Package branch_ckpt_pkg:
  - checkpoint_t struct (id, color, ghr, free_head, ds)
  - state enum {IDLE, RECOVER}
  - function is_younger(id_a, color_a, id_b, color_b)
- Sub-module: reuse the existing priority_encoder for free-slot selection. No new sub-module.

Test Plan:
- Reset, then 4 allocs with ids 3, 5, 7, 9 and color 0 → slots 0..3 granted in order; valid_mask=4'b1111; alloc_ready=0 on the 5th request.
- Correct resolve of id 5 with simultaneous alloc id 11 → alloc_ready=0 that cycle (full); next cycle slot 1 granted for id 11.
- Slots hold ids 3, 5, 7, 9; mispredict id 5, ghr[1]=8'hA5, ds=0 → next cycle recover_valid=1, recover_slot=1, recover_ghr=8'hA4, recover_youngest_ptr=6, valid_mask=4'b0001, alloc_ready=0; the following cycle recover_valid=0, alloc_ready=1.
- Wrap case: slot ids 62 (color 0) and 1 (color 1); mispredict id 62 with ds=1 → slot holding id 1 squashed, recover_youngest_ptr=0, recover_global_color=1.
- Resolve during RECOVER, and mispredict with a non-matching id → no change to valid_mask, no second pulse.
- rst_n=0 on the RECOVER cycle → recover_valid=0, valid_mask=0, alloc_ready=1 on the next cycle.

Source files
------------

// File: rtl/branch_ckpt_pkg.sv
// Shared types for the branch checkpoint manager:
// checkpoint slot layout, FSM states and the age compare.
package branch_ckpt_pkg;

  localparam int BRANCH_NUM             = 4;
  localparam int BRANCH_NUM_INDEX       = 2;
  localparam int ACTIVE_LIST_SIZE       = 64;
  localparam int ACTIVE_LIST_SIZE_INDEX = 6;
  localparam int PHYS_REG_NUM_INDEX     = 6;
  localparam int GHR_LEN                = 8;

  typedef struct packed {
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] id;
    logic                              color;
    logic [GHR_LEN-1:0]                ghr;
    logic [PHYS_REG_NUM_INDEX-1:0]     free_head;
    logic                              ds;
  } checkpoint_t;

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  // True when entry a was dispatched after branch b.
  function automatic logic is_younger(
    input logic [ACTIVE_LIST_SIZE_INDEX-1:0] id_a,
    input logic                              color_a,
    input logic [ACTIVE_LIST_SIZE_INDEX-1:0] id_b,
    input logic                              color_b
  );
    return (color_a == color_b) ? (id_a > id_b) : (id_a < id_b);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder.
// o_valid is low when no request bit is set.
module priority_encoder #(
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic [W-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_checkpoint_manager.sv
// Branch checkpoint slots: allocate on dispatch, free on resolve,
// squash younger slots and emit a one-cycle restore pulse on mispredict.
module branch_checkpoint_manager
  import branch_ckpt_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc_req,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0] alloc_branch_id,
  input  logic                              alloc_color,
  input  logic [GHR_LEN-1:0]                alloc_ghr,
  input  logic [PHYS_REG_NUM_INDEX-1:0]     alloc_free_head,
  input  logic                              alloc_ds,
  output logic                              alloc_ready,
  output logic [BRANCH_NUM_INDEX-1:0]       alloc_slot,
  input  logic                              resolve_valid,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0] resolve_branch_id,
  input  logic                              resolve_color,
  input  logic                              resolve_miss,
  output logic [BRANCH_NUM-1:0]             valid_mask,
  output logic                              recover_valid,
  output logic [BRANCH_NUM_INDEX-1:0]       recover_slot,
  output logic [GHR_LEN-1:0]                recover_ghr,
  output logic [PHYS_REG_NUM_INDEX-1:0]     recover_free_head,
  output logic [ACTIVE_LIST_SIZE_INDEX-1:0] recover_youngest_ptr,
  output logic                              recover_global_color
);

  localparam logic [ACTIVE_LIST_SIZE_INDEX-1:0] AL_LAST =
    ACTIVE_LIST_SIZE_INDEX'(ACTIVE_LIST_SIZE - 1);

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [BRANCH_NUM-1:0]               r_valid;
  logic [BRANCH_NUM-1:0]               w_valid_nxt;
  checkpoint_t                         r_ckpt [BRANCH_NUM];
  logic                                r_rec_valid;
  logic [BRANCH_NUM_INDEX-1:0]         r_rec_slot;
  logic [GHR_LEN-1:0]                  r_rec_ghr;
  logic [PHYS_REG_NUM_INDEX-1:0]       r_rec_fh;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0]   r_rec_ptr;
  logic                                r_rec_color;

  logic [BRANCH_NUM_INDEX-1:0]         w_free_idx;
  logic                                w_free_any;
  logic [BRANCH_NUM-1:0]               w_hit;
  logic [BRANCH_NUM_INDEX-1:0]         w_hit_idx;
  logic                                w_hit_any;
  logic                                w_alloc_fire;
  logic                                w_miss;
  logic [BRANCH_NUM-1:0]               w_kill;
  checkpoint_t                         w_m;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0]   w_last;
  logic                                w_last_color;

  priority_encoder #(.W(BRANCH_NUM), .IW(BRANCH_NUM_INDEX)) u_free_enc (
    .i_req   (~r_valid),
    .o_idx   (w_free_idx),
    .o_valid (w_free_any)
  );

  priority_encoder #(.W(BRANCH_NUM), .IW(BRANCH_NUM_INDEX)) u_hit_enc (
    .i_req   (w_hit),
    .o_idx   (w_hit_idx),
    .o_valid (w_hit_any)
  );

  assign alloc_ready  = w_free_any && (r_state == IDLE) &&
                        !(resolve_valid && resolve_miss);
  assign alloc_slot   = w_free_idx;
  assign w_alloc_fire = alloc_req && alloc_ready;
  assign w_miss       = w_hit_any && resolve_miss;
  assign w_m          = r_ckpt[w_hit_idx];

  // Resolves seen during RECOVER belong to squashed paths.
  always_comb begin
    w_hit  = '0;
    w_kill = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      w_hit[i]  = resolve_valid && (r_state == IDLE) && r_valid[i] &&
                  (r_ckpt[i].id == resolve_branch_id) &&
                  (r_ckpt[i].color == resolve_color);
      w_kill[i] = (w_hit_idx == BRANCH_NUM_INDEX'(i)) ||
                  is_younger(r_ckpt[i].id, r_ckpt[i].color,
                             w_m.id, w_m.color);
    end
  end

  assign w_last       = w_m.id + ACTIVE_LIST_SIZE_INDEX'(w_m.ds);
  assign w_last_color = w_m.color ^ (w_m.ds && (w_m.id == AL_LAST));

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_alloc_fire)
      w_valid_nxt[w_free_idx] = 1'b1;
    if (w_miss)
      w_valid_nxt = w_valid_nxt & ~w_kill;
    else if (w_hit_any)
      w_valid_nxt[w_hit_idx] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_miss) w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_rec_valid <= 1'b0;
      r_rec_slot  <= '0;
      r_rec_ghr   <= '0;
      r_rec_fh    <= '0;
      r_rec_ptr   <= '0;
      r_rec_color <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_rec_valid <= w_miss;
      if (w_miss) begin
        r_rec_slot  <= w_hit_idx;
        r_rec_ghr   <= {w_m.ghr[GHR_LEN-1:1], ~w_m.ghr[0]};
        r_rec_fh    <= w_m.free_head;
        r_rec_ptr   <= w_last + 1'b1;
        r_rec_color <= w_last_color ^ (w_last == AL_LAST);
      end
    end
  end

  // Slot payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_ckpt[w_free_idx] <= '{id:        alloc_branch_id,
                              color:     alloc_color,
                              ghr:       alloc_ghr,
                              free_head: alloc_free_head,
                              ds:        alloc_ds};
    end
  end

  assign valid_mask           = r_valid;
  assign recover_valid        = r_rec_valid;
  assign recover_slot         = r_rec_slot;
  assign recover_ghr          = r_rec_ghr;
  assign recover_free_head    = r_rec_fh;
  assign recover_youngest_ptr = r_rec_ptr;
  assign recover_global_color = r_rec_color;

endmodule

// File: tb/tb_branch_checkpoint_manager.sv
// Directed bench for branch_checkpoint_manager.
// Inputs change 1 time unit after posedge; outputs checked mid-cycle.
module tb_branch_checkpoint_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic [5:0] alloc_branch_id = '0;
  logic       alloc_color = 1'b0;
  logic [7:0] alloc_ghr = '0;
  logic [5:0] alloc_free_head = '0;
  logic       alloc_ds = 1'b0;
  logic       alloc_ready;
  logic [1:0] alloc_slot;
  logic       resolve_valid = 1'b0;
  logic [5:0] resolve_branch_id = '0;
  logic       resolve_color = 1'b0;
  logic       resolve_miss = 1'b0;
  logic [3:0] valid_mask;
  logic       recover_valid;
  logic [1:0] recover_slot;
  logic [7:0] recover_ghr;
  logic [5:0] recover_free_head;
  logic [5:0] recover_youngest_ptr;
  logic       recover_global_color;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_checkpoint_manager dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .alloc_req            (alloc_req),
    .alloc_branch_id      (alloc_branch_id),
    .alloc_color          (alloc_color),
    .alloc_ghr            (alloc_ghr),
    .alloc_free_head      (alloc_free_head),
    .alloc_ds             (alloc_ds),
    .alloc_ready          (alloc_ready),
    .alloc_slot           (alloc_slot),
    .resolve_valid        (resolve_valid),
    .resolve_branch_id    (resolve_branch_id),
    .resolve_color        (resolve_color),
    .resolve_miss         (resolve_miss),
    .valid_mask           (valid_mask),
    .recover_valid        (recover_valid),
    .recover_slot         (recover_slot),
    .recover_ghr          (recover_ghr),
    .recover_free_head    (recover_free_head),
    .recover_youngest_ptr (recover_youngest_ptr),
    .recover_global_color (recover_global_color)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req     = 1'b0;
    resolve_valid = 1'b0;
    resolve_miss  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_alloc(input logic [5:0] id, input logic c,
                          input logic [7:0] g, input logic [5:0] fh,
                          input logic ds);
    alloc_req       = 1'b1;
    alloc_branch_id = id;
    alloc_color     = c;
    alloc_ghr       = g;
    alloc_free_head = fh;
    alloc_ds        = ds;
    step();
    alloc_req = 1'b0;
    #1;
  endtask

  task automatic drive_resolve(input logic [5:0] id, input logic c,
                               input logic miss);
    resolve_valid     = 1'b1;
    resolve_branch_id = id;
    resolve_color     = c;
    resolve_miss      = miss;
    #1;
  endtask

  task automatic fill_3579();
    do_alloc(6'd3, 1'b0, 8'h11, 6'd10, 1'b0);
    do_alloc(6'd5, 1'b0, 8'hA5, 6'd21, 1'b0);
    do_alloc(6'd7, 1'b0, 8'h33, 6'd30, 1'b0);
    do_alloc(6'd9, 1'b0, 8'h44, 6'd40, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (valid_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0000", valid_mask);
    end
    n_tests++;
    if (recover_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover_valid: got %b want 0", recover_valid);
    end
    n_tests++;
    if ({recover_slot, recover_ghr, recover_free_head,
         recover_youngest_ptr, recover_global_color} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_recover_fields: slot %0d ghr %h fh %0d ptr %0d col %b want all 0",
               recover_slot, recover_ghr, recover_free_head,
               recover_youngest_ptr, recover_global_color);
    end
    n_tests++;
    if (alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready);
    end
  endtask

  task automatic test_alloc_fill();
    logic [5:0] ids [4];
    ids[0] = 6'd3; ids[1] = 6'd5; ids[2] = 6'd7; ids[3] = 6'd9;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc_req       = 1'b1;
      alloc_branch_id = ids[k];
      alloc_color     = 1'b0;
      #1;
      n_tests++;
      if (alloc_ready !== 1'b1 || alloc_slot !== 2'(k)) begin
        n_fail++;
        $display("FAIL alloc_grant_%0d: ready %b slot %0d want ready 1 slot %0d",
                 k, alloc_ready, alloc_slot, k);
      end
      step();
    end
    alloc_branch_id = 6'd11;
    #1;
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_full_ready: got %b want 0", alloc_ready);
    end
    step();
    alloc_req = 1'b0;
    n_tests++;
    if (valid_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL alloc_full_mask: got %b want 1111", valid_mask);
    end
  endtask

  task automatic test_resolve_with_alloc();
    do_reset();
    fill_3579();
    alloc_req       = 1'b1;
    alloc_branch_id = 6'd11;
    alloc_color     = 1'b0;
    drive_resolve(6'd5, 1'b0, 1'b0);
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_ready_full: got %b want 0", alloc_ready);
    end
    step();
    resolve_valid = 1'b0;
    #1;
    n_tests++;
    if (valid_mask !== 4'b1101) begin
      n_fail++;
      $display("FAIL simul_freed_mask: got %b want 1101", valid_mask);
    end
    n_tests++;
    if (alloc_ready !== 1'b1 || alloc_slot !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_regrant: ready %b slot %0d want ready 1 slot 1",
               alloc_ready, alloc_slot);
    end
    step();
    alloc_req = 1'b0;
    n_tests++;
    if (valid_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL simul_refill_mask: got %b want 1111", valid_mask);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    fill_3579();
    drive_resolve(6'd5, 1'b0, 1'b1);
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (recover_valid !== 1'b1 || recover_slot !== 2'd1) begin
      n_fail++;
      $display("FAIL miss_pulse: valid %b slot %0d want valid 1 slot 1",
               recover_valid, recover_slot);
    end
    n_tests++;
    if (recover_ghr !== 8'hA4 || recover_free_head !== 6'd21) begin
      n_fail++;
      $display("FAIL miss_ghr_fh: ghr %h fh %0d want ghr a4 fh 21",
               recover_ghr, recover_free_head);
    end
    n_tests++;
    if (recover_youngest_ptr !== 6'd6 || recover_global_color !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_ptr_color: ptr %0d col %b want ptr 6 col 0",
               recover_youngest_ptr, recover_global_color);
    end
    n_tests++;
    if (valid_mask !== 4'b0001 || alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_squash: mask %b ready %b want mask 0001 ready 0",
               valid_mask, alloc_ready);
    end
    step();
    n_tests++;
    if (recover_valid !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_return_idle: valid %b ready %b want valid 0 ready 1",
               recover_valid, alloc_ready);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_alloc(6'd60, 1'b0, 8'h00, 6'd1, 1'b0);
    do_alloc(6'd62, 1'b0, 8'h3C, 6'd7, 1'b1);
    do_alloc(6'd1,  1'b1, 8'h55, 6'd9, 1'b0);
    drive_resolve(6'd62, 1'b0, 1'b1);
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (recover_valid !== 1'b1 || recover_slot !== 2'd1 ||
        recover_ghr !== 8'h3D || recover_free_head !== 6'd7) begin
      n_fail++;
      $display("FAIL wrap_pulse: valid %b slot %0d ghr %h fh %0d want 1 1 3d 7",
               recover_valid, recover_slot, recover_ghr, recover_free_head);
    end
    n_tests++;
    if (recover_youngest_ptr !== 6'd0 || recover_global_color !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ptr_color: ptr %0d col %b want ptr 0 col 1",
               recover_youngest_ptr, recover_global_color);
    end
    n_tests++;
    if (valid_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_squash: got %b want 0001", valid_mask);
    end
    step();
  endtask

  task automatic test_ignored_resolves();
    do_reset();
    fill_3579();
    drive_resolve(6'd7, 1'b0, 1'b1);
    step();
    drive_resolve(6'd3, 1'b0, 1'b1);
    n_tests++;
    if (recover_valid !== 1'b1 || valid_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL ign_recover_state: valid %b mask %b want 1 0011",
               recover_valid, valid_mask);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (recover_valid !== 1'b0 || valid_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL ign_during_recover: valid %b mask %b want 0 0011",
               recover_valid, valid_mask);
    end
    drive_resolve(6'd40, 1'b0, 1'b1);
    step();
    drive_resolve(6'd5, 1'b1, 1'b1);
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (recover_valid !== 1'b0 || valid_mask !== 4'b0011 ||
        alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_nohit: valid %b mask %b ready %b want 0 0011 1",
               recover_valid, valid_mask, alloc_ready);
    end
  endtask

  task automatic test_reset_in_recover();
    do_reset();
    do_alloc(6'd3, 1'b0, 8'h10, 6'd2, 1'b0);
    do_alloc(6'd5, 1'b0, 8'h20, 6'd4, 1'b0);
    drive_resolve(6'd5, 1'b0, 1'b1);
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (recover_valid !== 1'b0 || valid_mask !== 4'b0000 ||
        alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_recover: valid %b mask %b ready %b want 0 0000 1",
               recover_valid, valid_mask, alloc_ready);
    end
    step();
    n_tests++;
    if (recover_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_late_pulse: got %b want 0", recover_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_3579();
    drive_resolve(6'd3, 1'b0, 1'b0);
    step();
    drive_resolve(6'd9, 1'b0, 1'b0);
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (valid_mask !== 4'b0110 || alloc_slot !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_free: mask %b slot %0d want 0110 0",
               valid_mask, alloc_slot);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_fill();
    test_resolve_with_alloc();
    test_mispredict();
    test_wrap();
    test_ignored_resolves();
    test_reset_in_recover();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
